// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state
// and the memory arbiter FSM state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        IDONE  = 3'd4,
        DDONE  = 3'd5
    } arb_state_t;

    function automatic logic is_access(input arb_state_t s);
        return (s == IFETCH) || (s == DREAD) || (s == DWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Priority dWEN > dREN > iREN; accesses retry until RAM reports ACCESS.
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t state_q;
    arb_state_t state_d;
    word_t      addr_q;
    word_t      data_q;
    word_t      iload_q;
    word_t      dload_q;
    logic       ram_ok;

    assign ram_ok = (ramstate == ACCESS);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is captured on leaving IDLE so the access is immune to input changes.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (state_q == IDLE) begin
            if (dWEN) begin
                addr_q <= daddr;
                data_q <= dstore;
            end else if (dREN) begin
                addr_q <= daddr;
            end else if (iREN) begin
                addr_q <= iaddr;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            iload_q <= '0;
            dload_q <= '0;
        end else if (ram_ok) begin
            if (state_q == IFETCH) begin
                iload_q <= ramload;
            end
            if (state_q == DREAD) begin
                dload_q <= ramload;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dWEN) begin
                    state_d = DWRITE;
                end else if (dREN) begin
                    state_d = DREAD;
                end else if (iREN) begin
                    state_d = IFETCH;
                end
            end
            IFETCH: if (ram_ok) state_d = IDONE;
            DREAD:  if (ram_ok) state_d = DDONE;
            DWRITE: if (ram_ok) state_d = DDONE;
            IDONE:  state_d = IDLE;
            DDONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low whenever reset is asserted.
    always_comb begin
        ihit     = 1'b0;
        dhit     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (nRST) begin
            unique case (state_q)
                IFETCH, DREAD: begin
                    ramREN  = 1'b1;
                    ramaddr = addr_q;
                end
                DWRITE: begin
                    ramWEN   = 1'b1;
                    ramaddr  = addr_q;
                    ramstore = data_q;
                end
                IDONE: ihit = 1'b1;
                DDONE: dhit = 1'b1;
                default: ;
            endcase
        end
    end

    assign iload = iload_q;
    assign dload = dload_q;

endmodule
